decode_issue: RTL and testbench
===============================

# decode_issue

Issue stage sitting between the fetch/decode (FD) pipeline register and the DX pipeline register. It is the transmitting end of the DX valid/ready handshake: accepts instructions from FD, buffers up to two in a skid buffer so its `ready_o` never depends combinationally on `ready_i`, and presents them in order to DX. It withholds issue on a load-use hazard against the instruction currently held in DX, discards everything on `pipeline_flush`, and counts hazard stall cycles.

## Interface
- `PCWidth`, 64, PC width.
- `RegAddrWidth`, 4, register index width; fields are taken from the low bits of the standard RISC-V positions.
- `StallCntWidth`, 16, width of the saturating stall counter.

Ports:
- `clk_i` in 1: clock.
- `reset_ni` in 1: reset, synchronous, active-low.
- `pipeline_flush` in 1: drop all buffered entries and any same-cycle input.
- `instr_i` in 32: instruction from FD.
- `PC_i` in PCWidth: PC of `instr_i`.
- `valid_i` in 1: FD offers an instruction.
- `ready_o` out 1: this block accepts this cycle.
- `dx_valid_i` in 1: DX register is FULL.
- `dx_MemRead_i` in 1: instruction in DX is a load.
- `dx_rd_i` in RegAddrWidth: destination register of the instruction in DX.
- `instr_o` out 32: head instruction.
- `PC_o` out PCWidth: head PC.
- `rd_o`, `rs1_o`, `rs2_o` out RegAddrWidth each: `instr[7 +: RegAddrWidth]`, `instr[15 +: RegAddrWidth]`, `instr[20 +: RegAddrWidth]` of the head.
- `valid_o` out 1: head offered to DX.
- `ready_i` in 1: DX accepts.
- `stall_cnt_o` out StallCntWidth: count of hazard-stall cycles.

## Operation
- Two-entry in-order buffer: head (entry 0) and skid (entry 1). State machine EMPTY / ONE / TWO.
- accept = `valid_i & ready_o`; issue = `valid_o & ready_i`.
- `ready_o` = (state != TWO) and not in reset. It is a function of registered state only.
- hazard = head valid & `dx_valid_i` & `dx_MemRead_i` & (`dx_rd_i` != 0) & (`dx_rd_i` == rs1 of head or `dx_rd_i` == rs2 of head).
  - rs2 is compared for every format, so the check is conservative.
- `valid_o` = (state != EMPTY) & !hazard & !`pipeline_flush`.
- Transitions (no flush):
  - EMPTY: accept -> ONE, with the input written to head.
  - ONE:
    - accept & issue -> ONE, with the input written to head.
    - accept only -> TWO, with the input written to skid.
    - issue only -> EMPTY.
  - TWO: issue -> ONE, with skid moved to head. No accept is possible in TWO.
- `pipeline_flush`:
  - Next state is EMPTY regardless of state, accept or issue.
  - Same-cycle input is discarded, although `ready_o` still reflects state.
  - `valid_o` is forced 0 that cycle.
- Stall counter: +1 on each cycle with head valid & hazard & !flush. It saturates at all-ones and is cleared only by reset.
- Output data (`instr_o`, `PC_o`, the reg fields) always shows the head entry, including when `valid_o` = 0.

## Timing
- Reset (`reset_ni` low at a clock edge):
  - state becomes EMPTY; all entries and `stall_cnt_o` become 0.
  - `valid_o` = 0. `ready_o` = 0 while `reset_ni` is low and 1 on the first cycle after release.
- Latency: an instruction accepted at edge N can be offered (`valid_o` = 1) in cycle N+1. That is 1 cycle with no hazard.
- Throughput: 1 instruction/cycle sustained when `ready_i` = 1 and there is no hazard.
- Back-pressure: when `ready_i` drops, one more instruction is absorbed into skid. `ready_o` falls the cycle after entering TWO.
- The only combinational paths to `valid_o` are from `pipeline_flush`, `dx_valid_i`, `dx_MemRead_i` and `dx_rd_i`. There is no path from `ready_i` to `ready_o`.
- Hazard clears in the cycle DX reports `dx_valid_i` = 0 or a non-matching `dx_rd_i`; the head issues that same cycle if `ready_i` = 1.
- Once `valid_o` = 1 without hazard, data is held stable until issue or flush.

## Test plan
- Reset, then stream 4 instructions (PC 0x0, 0x4, 0x8, 0xC) with `ready_i` = 1 -> `valid_o` from cycle 1. Each is issued the cycle after accept, in order, and `ready_o` stays 1.
- Back-pressure: fill with PCs 0x10 and 0x14 while `ready_i` = 0 -> state TWO, `ready_o` = 0. Raise `ready_i` -> 0x10 then 0x14 issue on consecutive cycles with no loss or duplication.
- Load-use: head `add x3,x1,x2`, DX holds `lw x1` (`dx_valid_i` = 1, `dx_MemRead_i` = 1, `dx_rd_i` = 1) for 2 cycles -> `valid_o` = 0 for 2 cycles and `stall_cnt_o` = 2, then issue.
- Hazard exclusions: `dx_rd_i` = 0, or `dx_MemRead_i` = 0, or a non-matching rd -> no stall and `stall_cnt_o` unchanged.
- Flush in state TWO with `valid_i` = 1 -> next cycle EMPTY, `valid_o` = 0, `ready_o` = 1. The flushed and same-cycle instructions never appear at the outputs.
- Saturation: with `StallCntWidth` = 4, hold a hazard for 20 cycles -> `stall_cnt_o` = 0xF. Reset mid-operation -> all outputs 0 and state EMPTY after one edge.

Source files
------------

// File: rtl/decode_issue_if.sv
// Issue-stage bus: FD-side accept handshake plus DX-side issue handshake and load-use inputs.
// Latency: none, wires only.
// Backpressure: ready_o toward FD, ready_i from DX.
interface decode_issue_if #(
   parameter int PCWidth      = 64,
   parameter int RegAddrWidth = 4
);
   // FD side
   logic [31:0]             instr_i;
   logic [PCWidth-1:0]      PC_i;
   logic                    valid_i;
   logic                    ready_o;
   // DX occupancy, used for load-use detection
   logic                    dx_valid_i;
   logic                    dx_MemRead_i;
   logic [RegAddrWidth-1:0] dx_rd_i;
   // DX side
   logic [31:0]             instr_o;
   logic [PCWidth-1:0]      PC_o;
   logic [RegAddrWidth-1:0] rd_o;
   logic [RegAddrWidth-1:0] rs1_o;
   logic [RegAddrWidth-1:0] rs2_o;
   logic                    valid_o;
   logic                    ready_i;

   // Issue stage view
   modport master (
      input  instr_i, PC_i, valid_i,
      input  dx_valid_i, dx_MemRead_i, dx_rd_i,
      input  ready_i,
      output ready_o,
      output instr_o, PC_o, rd_o, rs1_o, rs2_o, valid_o
   );

   // Surrounding pipeline view
   modport slave (
      output instr_i, PC_i, valid_i,
      output dx_valid_i, dx_MemRead_i, dx_rd_i,
      output ready_i,
      input  ready_o,
      input  instr_o, PC_o, rd_o, rs1_o, rs2_o, valid_o
   );
endinterface

// File: rtl/decode_issue.sv
// Issue stage: 2-entry in-order skid buffer between FD and DX with load-use hold and stall counter.
// Latency: 1 cycle from accept to valid_o when no hazard; 1 instr/cycle sustained.
// Backpressure: ready_o from registered occupancy only; a drop of ready_i is absorbed by the skid entry.
module decode_issue #(
   parameter int PCWidth       = 64,
   parameter int RegAddrWidth  = 4,
   parameter int StallCntWidth = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     pipeline_flush,
   decode_issue_if.master           bus,
   output logic [StallCntWidth-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [31:0]               head_instr_q, head_instr_d;
   logic [PCWidth-1:0]        head_pc_q, head_pc_d;
   logic [31:0]               skid_instr_q, skid_instr_d;
   logic [PCWidth-1:0]        skid_pc_q, skid_pc_d;
   logic [StallCntWidth-1:0]  stall_cnt_q, stall_cnt_d;

   logic                      head_vld;
   logic [RegAddrWidth-1:0]   head_rs1;
   logic [RegAddrWidth-1:0]   head_rs2;
   logic                      hazard;
   logic                      accept;
   logic                      issue;

   assign head_vld = (state_q != S_EMPTY);
   assign head_rs1 = head_instr_q[15 +: RegAddrWidth];
   assign head_rs2 = head_instr_q[20 +: RegAddrWidth];

   // Load-use check against DX; rs2 compared for every format, so it may stall needlessly but never misses
   assign hazard = head_vld & bus.dx_valid_i & bus.dx_MemRead_i & (bus.dx_rd_i != '0) &
                   ((bus.dx_rd_i == head_rs1) | (bus.dx_rd_i == head_rs2));

   assign bus.ready_o = (state_q != S_TWO) & reset_ni;
   assign bus.valid_o = head_vld & ~hazard & ~pipeline_flush;

   assign accept = bus.valid_i & bus.ready_o;
   assign issue  = bus.valid_o & bus.ready_i;

   // Head entry is always visible, even while withheld
   assign bus.instr_o   = head_instr_q;
   assign bus.PC_o      = head_pc_q;
   assign bus.rd_o      = head_instr_q[7 +: RegAddrWidth];
   assign bus.rs1_o     = head_rs1;
   assign bus.rs2_o     = head_rs2;
   assign stall_cnt_o   = stall_cnt_q;

   // Next occupancy and entry contents; flush empties and clears both entries and drops the input
   always_comb begin
      state_d      = state_q;
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (pipeline_flush) begin
         state_d      = S_EMPTY;
         head_instr_d = '0;
         head_pc_d    = '0;
         skid_instr_d = '0;
         skid_pc_d    = '0;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d      = S_ONE;
                  head_instr_d = bus.instr_i;
                  head_pc_d    = bus.PC_i;
               end
            end
            S_ONE: begin
               if (accept && issue) begin
                  head_instr_d = bus.instr_i;
                  head_pc_d    = bus.PC_i;
               end else if (accept) begin
                  state_d      = S_TWO;
                  skid_instr_d = bus.instr_i;
                  skid_pc_d    = bus.PC_i;
               end else if (issue) begin
                  state_d      = S_EMPTY;
               end
            end
            S_TWO: begin
               // ready_o is low here, so only an issue can move the buffer
               if (issue) begin
                  state_d      = S_ONE;
                  head_instr_d = skid_instr_q;
                  head_pc_d    = skid_pc_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Saturating count of cycles the head is held back by a load-use hazard
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && !pipeline_flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + StallCntWidth'(1);
      end
   end

   // State and entry registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= S_EMPTY;
         head_instr_q <= '0;
         head_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         head_instr_q <= head_instr_d;
         head_pc_q    <= head_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios then random traffic against a queue-based reference.
// Latency: outputs checked 1 time unit after each falling edge, model advanced per rising edge.
// Backpressure: ready_i, flush, reset and DX hazard inputs driven directly and randomly.
module tb_decode_issue;
   localparam int PCW = 64;
   localparam int RAW = 4;
   localparam int SCW = 4;
   localparam int SAT = (1 << SCW) - 1;

   typedef struct packed {
      logic [31:0]  instr;
      logic [63:0]  pc;
   } ent_t;

   logic            clk_i = 1'b0;
   logic            reset_ni = 1'b0;
   logic            pipeline_flush = 1'b0;
   logic [SCW-1:0]  stall_cnt_o;

   decode_issue_if #(.PCWidth(PCW), .RegAddrWidth(RAW)) bus ();

   decode_issue #(.PCWidth(PCW), .RegAddrWidth(RAW), .StallCntWidth(SCW)) dut (
      .clk_i          (clk_i),
      .reset_ni       (reset_ni),
      .pipeline_flush (pipeline_flush),
      .bus            (bus),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: list of buffered instructions, last shown head, hazard cycle count
   ent_t q[$];
   ent_t held;
   int   cnt;
   int   issued;
   int   checks;
   int   errors;

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic rdy,
                         input logic dv, input logic mr, input logic [3:0] drd,
                         input logic fl, input logic rst_n);
      bus.valid_i      = v;
      bus.instr_i      = ins;
      bus.PC_i         = pc;
      bus.ready_i      = rdy;
      bus.dx_valid_i   = dv;
      bus.dx_MemRead_i = mr;
      bus.dx_rd_i      = drd;
      pipeline_flush   = fl;
      reset_ni         = rst_n;
   endtask

   // Compare all outputs with the reference, advance the reference across the next rising edge
   task automatic cycle();
      ent_t       h;
      logic [3:0] rs1, rs2;
      logic       e_haz, e_vld, e_rdy;
      #1;
      h     = (q.size() > 0) ? q[0] : held;
      rs1   = h.instr[15 +: 4];
      rs2   = h.instr[20 +: 4];
      e_haz = (q.size() > 0) && bus.dx_valid_i && bus.dx_MemRead_i && (bus.dx_rd_i != 4'd0) &&
              ((bus.dx_rd_i == rs1) || (bus.dx_rd_i == rs2));
      e_rdy = reset_ni && (q.size() < 2);
      e_vld = (q.size() > 0) && !e_haz && !pipeline_flush;
      chk("ready_o", bus.ready_o, e_rdy);
      chk("valid_o", bus.valid_o, e_vld);
      chk("instr_o", bus.instr_o, h.instr);
      chk("PC_o", bus.PC_o, h.pc);
      chk("rd_o", bus.rd_o, h.instr[7 +: 4]);
      chk("rs1_o", bus.rs1_o, rs1);
      chk("rs2_o", bus.rs2_o, rs2);
      chk("stall_cnt_o", stall_cnt_o, cnt);
      if (!reset_ni) begin
         q.delete();
         held = '0;
         cnt  = 0;
      end else if (pipeline_flush) begin
         q.delete();
         held = '0;
      end else begin
         if (e_haz) cnt = (cnt == SAT) ? SAT : cnt + 1;
         if (e_vld && bus.ready_i) begin
            void'(q.pop_front());
            issued++;
         end
         if (bus.valid_i && e_rdy) q.push_back('{instr: bus.instr_i, pc: bus.PC_i});
         if (q.size() > 0) held = q[0];
      end
      @(negedge clk_i);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      issued = 0;
      cnt    = 0;
      held   = '0;

      // Reset
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      cycle();
      cycle();

      // Stream four instructions with DX always ready
      for (int i = 0; i < 4; i++) begin
         set_in(1, mk(5'(i + 5), 5'(i + 6), 5'(i + 7)), 64'(i * 4), 1, 0, 0, 0, 0, 1);
         cycle();
      end
      set_in(0, 0, 0, 1, 0, 0, 0, 0, 1);
      cycle();
      chk("stream_issued", issued, 4);

      // Back-pressure: fill both entries, ready_o then low
      set_in(1, mk(1, 2, 3), 64'h10, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(1, mk(4, 5, 6), 64'h14, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(1, mk(7, 8, 9), 64'h18, 0, 0, 0, 0, 0, 1);
      #1 chk("bp_ready_low", bus.ready_o, 1'b0);
      cycle();
      set_in(0, 0, 0, 1, 0, 0, 0, 0, 1);
      cycle();
      cycle();
      chk("bp_issued", issued, 6);

      // Load-use: add x3,x1,x2 behind lw x1 for two cycles
      set_in(1, mk(3, 1, 2), 64'h20, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(0, 0, 0, 1, 1, 1, 4'd1, 0, 1);
      cycle();
      cycle();
      chk("lu_stall_cnt", stall_cnt_o, 2);
      set_in(0, 0, 0, 1, 0, 1, 4'd1, 0, 1);
      cycle();
      chk("lu_issued", issued, 7);

      // Hazard exclusions: rd zero, not a load, non-matching rd, DX empty
      set_in(1, mk(3, 1, 2), 64'h24, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(0, 0, 0, 1, 1, 1, 4'd0, 0, 1);
      #1 chk("excl_rd0_valid", bus.valid_o, 1'b1);
      set_in(0, 0, 0, 0, 1, 1, 4'd0, 0, 1);
      cycle();
      set_in(0, 0, 0, 0, 1, 0, 4'd1, 0, 1);
      cycle();
      set_in(0, 0, 0, 0, 1, 1, 4'd5, 0, 1);
      cycle();
      set_in(0, 0, 0, 0, 0, 1, 4'd2, 0, 1);
      cycle();
      chk("excl_stall_cnt", stall_cnt_o, 2);
      set_in(0, 0, 0, 1, 1, 1, 4'd4, 0, 1);
      cycle();
      chk("excl_issued", issued, 8);

      // Flush while full with a same-cycle offer
      set_in(1, mk(1, 1, 1), 64'h30, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(1, mk(2, 2, 2), 64'h34, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(1, mk(3, 3, 3), 64'h38, 1, 0, 0, 0, 1, 1);
      cycle();
      set_in(0, 0, 0, 1, 0, 0, 0, 0, 1);
      #1;
      chk("flush_valid", bus.valid_o, 1'b0);
      chk("flush_ready", bus.ready_o, 1'b1);
      cycle();
      cycle();
      chk("flush_issued", issued, 8);

      // Counter saturation under a 20-cycle hazard
      set_in(1, mk(3, 1, 2), 64'h40, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(0, 0, 0, 1, 1, 1, 4'd2, 0, 1);
      repeat (20) cycle();
      chk("sat_stall_cnt", stall_cnt_o, 4'hF);

      // Reset with both entries full
      set_in(1, mk(6, 6, 6), 64'h44, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      #1;
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_ready", bus.ready_o, 1'b0);
      chk("rst_pc", bus.PC_o, 64'h0);
      chk("rst_instr", bus.instr_o, 32'h0);
      chk("rst_cnt", stall_cnt_o, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         set_in(($urandom_range(0, 3) != 0),
                mk(5'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                {32'h0, $urandom},
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 59) != 0));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
